// File: rtl/frame_stream_mem_writer_pkg.sv
// Shared types and helpers for the stream-to-RAM frame writer.
// Defaults match the 32-bit x 32768-word on-chip RAM behind the writer.
package frame_stream_mem_writer_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 15;
  localparam int DEF_FIFO_DEPTH = 8;

  // Widest byte-lane vector the helper below can build; snk_empty is 2 bits wide.
  localparam int MAX_BE_W       = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEEK    = 2'd1,
    CAPTURE = 2'd2,
    FLUSH   = 2'd3
  } wr_state_t;

  // Valid lanes on an EOP beat sit at the low end, so shift the all-ones mask down.
  function automatic logic [MAX_BE_W-1:0] be_from_empty(input int unsigned be_w,
                                                        input logic [1:0] empty);
    logic [MAX_BE_W-1:0] ones;
    ones = '0;
    for (int unsigned i = 0; i < MAX_BE_W; i++) begin
      if (i < be_w) ones[i] = 1'b1;
    end
    return ones >> empty;
  endfunction

endpackage

// File: rtl/frame_stream_mem_writer_sync_fifo.sv
// Single-clock FIFO that holds captured beats while the RAM clock enable is low.
// Entries are {eop, empty, data}; depth must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is fine when the head leaves on the same edge.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frame_stream_mem_writer.sv
// Captures one Avalon-ST packet per start command and writes it into on-chip RAM
// through a registered Avalon-MM write master starting at a programmable base.
//
// state   | meaning
// IDLE    | ready high, beats discarded, waiting for start
// SEEK    | armed, discarding beats until one carries sop
// CAPTURE | storing beats up to the word limit, dropping the rest until eop
// FLUSH   | packet closed, draining FIFO and pending write, then pulse done
module frame_stream_mem_writer
  import frame_stream_mem_writer_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   cfg_base,
  input  logic [ADDR_W:0]     cfg_max_words,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [ADDR_W:0]     words_written,
  input  logic                snk_valid,
  output logic                snk_ready,
  input  logic [DATA_W-1:0]   snk_data,
  input  logic                snk_sop,
  input  logic                snk_eop,
  input  logic [1:0]          snk_empty,
  input  logic                mem_ready,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata
);

  localparam int BE_W    = DATA_W / 8;
  localparam int ENTRY_W = DATA_W + 3;

  wr_state_t state_q, state_d;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   max_q;
  logic [ADDR_W:0]   acc_cnt_q;
  logic [ADDR_W-1:0] wr_idx_q;
  logic              overflow_q;
  logic [ADDR_W:0]   words_q;
  logic              done_q;

  logic              accept;
  logic              under_limit;
  logic              start_ok;
  logic              push;
  logic              drop_over;
  logic              flush_done;

  logic [ENTRY_W-1:0] fifo_wr_data;
  logic [ENTRY_W-1:0] fifo_rd_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               commit;

  logic               head_eop;
  logic [1:0]         head_empty;
  logic [DATA_W-1:0]  head_data;
  logic [BE_W-1:0]    head_be;

  assign accept      = snk_valid & snk_ready;
  assign under_limit = (acc_cnt_q < max_q);

  always_comb begin
    state_d    = state_q;
    snk_ready  = 1'b1;
    start_ok   = 1'b0;
    push       = 1'b0;
    drop_over  = 1'b0;
    flush_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = SEEK;
        end
      end
      SEEK: begin
        if (accept && snk_sop) begin
          push      = under_limit;
          drop_over = ~under_limit;
          state_d   = snk_eop ? FLUSH : CAPTURE;
        end
      end
      CAPTURE: begin
        // Once the limit is reached beats are swallowed, so the FIFO level no longer matters.
        snk_ready = under_limit ? ~fifo_full : 1'b1;
        if (accept) begin
          push      = under_limit;
          drop_over = ~under_limit;
          if (snk_eop) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (fifo_empty && !mem_write) begin
          flush_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  assign fifo_wr_data = {snk_eop, snk_empty, snk_data};

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wr_data (fifo_wr_data),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head_eop   = fifo_rd_data[ENTRY_W-1];
  assign head_empty = fifo_rd_data[DATA_W+1:DATA_W];
  assign head_data  = fifo_rd_data[DATA_W-1:0];
  assign head_be    = head_eop ? BE_W'(be_from_empty(BE_W, head_empty)) : {BE_W{1'b1}};

  assign commit = mem_write & mem_ready;
  assign pop    = ~fifo_empty & (~mem_write | mem_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q     <= '0;
      max_q      <= '0;
      acc_cnt_q  <= '0;
      wr_idx_q   <= '0;
      overflow_q <= 1'b0;
      words_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= flush_done;
      if (start_ok) begin
        base_q     <= cfg_base;
        max_q      <= cfg_max_words;
        acc_cnt_q  <= '0;
        wr_idx_q   <= '0;
        overflow_q <= 1'b0;
        words_q    <= '0;
      end else begin
        if (push)      acc_cnt_q  <= acc_cnt_q + (ADDR_W+1)'(1);
        if (drop_over) overflow_q <= 1'b1;
        if (pop)       wr_idx_q   <= wr_idx_q + ADDR_W'(1);
        if (commit && (words_q < max_q)) words_q <= words_q + (ADDR_W+1)'(1);
      end
    end
  end

  // The write master only changes on a pop or a commit; a stalled write keeps every mem_* bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_byteenable <= '0;
      mem_writedata  <= '0;
    end else if (pop) begin
      mem_chipselect <= 1'b1;
      mem_write      <= 1'b1;
      mem_address    <= base_q + wr_idx_q;
      mem_byteenable <= head_be;
      mem_writedata  <= head_data;
    end else if (commit) begin
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign overflow      = overflow_q;
  assign words_written = words_q;

endmodule

// File: doc/frame_stream_mem_writer.md
Name: frame_stream_mem_writer

Overview:
- Avalon-ST sink to Avalon-MM write-master bridge. Sits directly upstream of the 32-bit x 32768-word single-port on-chip RAM (s1 slave).
- Captures one camera/detection packet (SOP..EOP) per start command and writes it word-by-word into RAM from a programmable base address, so the Nios software can read the result.
- Small internal FIFO absorbs RAM clock-enable stalls.

Parameters:
- DATA_W, 32, stream and memory data width (bytes = DATA_W/8)
- ADDR_W, 15, RAM word-address width
- FIFO_DEPTH, 8, internal FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle command: arm capture
- cfg_base  in  ADDR_W  first word address, latched on start
- cfg_max_words  in  ADDR_W+1  packet word limit, latched on start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of capture
- overflow  out  1  sticky: packet exceeded limit, cleared on start
- words_written  out  ADDR_W+1  committed RAM writes this capture
- snk_valid  in  1  stream beat valid
- snk_ready  out  1  stream backpressure
- snk_data  in  DATA_W  stream payload
- snk_sop  in  1  start of packet
- snk_eop  in  1  end of packet
- snk_empty  in  2  unused bytes in EOP beat
- mem_ready  in  1  RAM clock enable (clken & ~reset_req)
- mem_chipselect  out  1  RAM chipselect
- mem_write  out  1  RAM write strobe
- mem_address  out  ADDR_W  RAM word address
- mem_byteenable  out  DATA_W/8  byte lanes
- mem_writedata  out  DATA_W  write data

Behaviour:
- Reset values: busy=0, done=0, overflow=0, words_written=0, mem_chipselect=0, mem_write=0, mem_address=0, mem_byteenable=0, mem_writedata=0, FIFO empty, state IDLE. Async reset mid-capture abandons the frame; no partial write is completed.
- Beat accepted on a rising edge with snk_valid & snk_ready.
- FSM:
  - IDLE: snk_ready=1, beats discarded. start -> latch cfg, clear overflow/words_written, busy=1, go to SEEK.
  - SEEK: snk_ready=1, discard until accepted beat has sop. That beat is pushed (or dropped if cfg_max_words=0), counted, go to CAPTURE. If the same beat has eop, go straight to FLUSH.
  - CAPTURE: snk_ready = ~fifo_full, or 1 while dropping. Push accepted beats while accepted count < cfg_max_words; beyond that, accept and drop beats and set overflow. Accepted eop -> FLUSH. A sop inside CAPTURE is treated as ordinary data.
  - FLUSH: snk_ready=1, discard. When FIFO empty and no write pending, pulse done for 1 cycle, busy=0, go to IDLE.
- start while busy is ignored.
- Write side:
  - mem_* are registered.
  - When no write is pending (or the pending write commits this edge) and the FIFO is non-empty, pop the head into the mem_* registers with mem_write=mem_chipselect=1.
  - A write commits on an edge where mem_write & mem_ready. With mem_ready=0, all mem_* hold.
  - Throughput: 1 word/cycle when mem_ready=1.
  - Latency: beat accepted at edge N -> mem_write visible after edge N+1, commits at edge N+2 if mem_ready.
- Address: cfg_base + write_index, modulo 2^ADDR_W (wraps 32767 -> 0).
- byteenable: all ones, except on the stored EOP beat, where it is all-ones >> snk_empty (low lanes valid).
- words_written increments on each commit and saturates at cfg_max_words.
- Simultaneous pop and push on a full FIFO is allowed. snk_ready stays based on the registered full flag.

Decomposition:
- Package frame_stream_mem_writer_pkg: state enum (IDLE, SEEK, CAPTURE, FLUSH), default widths, byteenable-from-empty function.
- Sub-module sync_fifo: single-clock, async active-low reset, parameterised width/depth, full/empty flags. Entry = {eop, empty, data}.

Test Plan:
- start with base=0x0100, max=16; 4-beat packet 0xA0..0xA3, mem_ready=1 -> writes at 0x0100..0x0103 on 4 consecutive cycles, done pulse, words_written=4, overflow=0.
- Beats before sop, plus beats sent in IDLE -> snk_ready=1, no RAM writes; capture begins at the sop beat.
- base=0x7FFE, 4-beat packet -> addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001.
- max=2, 5-beat packet -> only 2 writes, overflow=1 sticky, done after eop, words_written=2; next start clears overflow.
- mem_ready held low 12 cycles during a 20-beat packet -> FIFO fills, snk_ready=0 after 8 pushes plus the pending word, mem_* stable; all 20 words written in order after release.
- EOP beat with snk_empty=3 -> last write byteenable=4'b0001. Reset asserted mid-packet -> all outputs at reset values immediately; next start captures cleanly.
